pio_master: RTL and testbench

//  Initiator end of the classifier PIO bus: converts single register read/write

---
 rtl/pio_master.sv | 199 +++++++++++++++++++
 tb/tb_pio_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_master.sv
// PIO bus initiator: turns one host read/write request into the start/address,
// data and ack/rvalid beat sequence paced by clk_div. Optional ack/rvalid
// timeout is built when PIO_MASTER_TIMEOUT_EN is defined.
module pio_master #(
  parameter int PIO_NBITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic                 req_rw,
  input  logic [PIO_NBITS-1:0] req_addr,
  input  logic [PIO_NBITS-1:0] req_wdata,
  output logic                 rsp_vld,
  output logic [PIO_NBITS-1:0] rsp_rdata,
  output logic                 rsp_err,
  input  logic                 clk_div,
  output logic                 pio_start,
  output logic                 pio_rw,
  output logic [PIO_NBITS-1:0] pio_addr_wdata,
  input  logic                 pio_ack,
  input  logic                 pio_rvalid,
  input  logic [PIO_NBITS-1:0] pio_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WAIT_ACK,
    S_WAIT_RD,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 req_rdy_q, req_rdy_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [PIO_NBITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 pio_start_q, pio_start_d;
  logic                 pio_rw_q, pio_rw_d;
  logic [PIO_NBITS-1:0] pio_data_q, pio_data_d;
  logic                 rw_q, rw_d;
  logic [PIO_NBITS-1:0] addr_q, addr_d;
  logic [PIO_NBITS-1:0] wdata_q, wdata_d;
  logic                 expired;

`ifdef PIO_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts every clk spent waiting; restarts whenever WAIT_ACK is entered.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_WAIT_ACK || state_q == S_WAIT_RD) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_d == S_WAIT_ACK && state_q != S_WAIT_ACK) begin
      cnt_d = '0;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_rdy_d   = req_rdy_q;
    rsp_vld_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    pio_start_d = pio_start_q;
    pio_rw_d    = pio_rw_q;
    pio_data_d  = pio_data_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    // Beats that carry no address or data drive the bus back to zero.
    if (clk_div && state_q != S_ADDR && state_q != S_DATA) begin
      pio_start_d = 1'b0;
      pio_data_d  = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req_vld && req_rdy_q) begin
          rw_d      = req_rw;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          req_rdy_d = 1'b0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (clk_div) begin
          pio_start_d = 1'b1;
          pio_rw_d    = rw_q;
          pio_data_d  = addr_q;
          state_d     = rw_q ? S_WAIT_ACK : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_div) begin
          pio_start_d = 1'b0;
          pio_data_d  = wdata_q;
          state_d     = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (pio_ack) begin
          if (!rw_q) begin
            rsp_vld_d = 1'b1;
            state_d   = S_RESP;
          end else if (pio_rvalid) begin
            rsp_vld_d   = 1'b1;
            rsp_rdata_d = pio_rdata;
            state_d     = S_RESP;
          end else begin
            state_d = S_WAIT_RD;
          end
        end else if (expired) begin
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_WAIT_RD: begin
        if (pio_rvalid) begin
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = pio_rdata;
          state_d     = S_RESP;
        end else if (expired) begin
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        req_rdy_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        req_rdy_d = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_rdy_q   <= 1'b1;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      pio_start_q <= 1'b0;
      pio_rw_q    <= 1'b0;
      pio_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_rdy_q   <= req_rdy_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      pio_start_q <= pio_start_d;
      pio_rw_q    <= pio_rw_d;
      pio_data_q  <= pio_data_d;
    end
  end

  // Request capture is pure data and needs no reset.
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign req_rdy        = req_rdy_q;
  assign rsp_vld        = rsp_vld_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign pio_start      = pio_start_q;
  assign pio_rw         = pio_rw_q;
  assign pio_addr_wdata = pio_data_q;

endmodule

// File: tb/tb_pio_master.sv
// Directed bench for pio_master: transaction-level model with per-cycle compare,
// plus literal expectations for the documented scenarios.
module tb_pio_master;

  localparam int NB = 32;
  localparam int TO = 16;
`ifdef PIO_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk, rst;
  logic          req_vld, req_rdy, req_rw;
  logic [NB-1:0] req_addr, req_wdata;
  logic          rsp_vld, rsp_err;
  logic [NB-1:0] rsp_rdata;
  logic          clk_div;
  logic          pio_start, pio_rw;
  logic [NB-1:0] pio_addr_wdata;
  logic          pio_ack, pio_rvalid;
  logic [NB-1:0] pio_rdata;

  pio_master #(.PIO_NBITS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .clk_div(clk_div),
    .pio_start(pio_start), .pio_rw(pio_rw), .pio_addr_wdata(pio_addr_wdata),
    .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit div_mode = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    clk_div = 1'b1;
    forever begin
      @(negedge clk);
      clk_div = div_mode ? ((cyc % 4) == 3) : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a queue of pending bus beats and a response rule.
  typedef struct {
    logic          st;
    logic          rw;
    logic [NB-1:0] d;
  } beat_t;

  beat_t         bq[$];
  beat_t         b;
  logic          e_rdy, e_vld, e_err, e_start, e_rw;
  logic [NB-1:0] e_rdata, e_pd;
  bit            m_active, m_rw, m_acked, m_after_rsp, m_accept, m_waiting, m_done;
  int            m_wcnt;

  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      m_active = 0; m_acked = 0; m_after_rsp = 0; m_wcnt = 0;
      e_rdy = 1; e_vld = 0; e_err = 0; e_rdata = '0;
      e_start = 0; e_rw = 0; e_pd = '0;
    end else begin
      m_accept  = e_rdy && req_vld;
      m_waiting = m_active && (bq.size() == 0);
      if (clk_div) begin
        if (m_active && bq.size() != 0) begin
          b = bq.pop_front();
          e_start = b.st;
          e_pd    = b.d;
          if (b.st) e_rw = b.rw;
        end else begin
          e_start = 0;
          e_pd    = '0;
        end
      end
      e_vld = 0; e_err = 0; e_rdata = '0;
      if (m_after_rsp) begin
        e_rdy = 1;
        m_after_rsp = 0;
      end
      if (m_waiting) begin
        m_done = 0;
        if (!m_acked) begin
          if (pio_ack) begin
            if (!m_rw) m_done = 1;
            else if (pio_rvalid) begin m_done = 1; e_rdata = pio_rdata; end
            else m_acked = 1;
          end
        end else if (pio_rvalid) begin
          m_done = 1;
          e_rdata = pio_rdata;
        end
        if (!m_done && TO_EN && m_wcnt == TO - 1) begin
          m_done = 1;
          e_err = 1;
        end
        if (m_done) begin
          e_vld = 1;
          m_active = 0;
          m_after_rsp = 1;
        end
        m_wcnt++;
      end
      if (m_accept) begin
        e_rdy = 0;
        m_active = 1; m_acked = 0; m_wcnt = 0; m_rw = req_rw;
        bq.push_back('{1'b1, req_rw, req_addr});
        if (!req_rw) bq.push_back('{1'b0, 1'b0, req_wdata});
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_rdy", req_rdy, e_rdy);
      chk("rsp_vld", rsp_vld, e_vld);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("pio_start", pio_start, e_start);
      chk("pio_rw", pio_rw, e_rw);
      chk("pio_addr_wdata", pio_addr_wdata, e_pd);
    end
  end

  // Response and beat-hold monitors used by the literal expectations.
  int            rsp_cnt = 0, rsp_cyc = 0, hi_cnt = 0, d5_cnt = 0;
  logic [NB-1:0] rsp_rd;
  logic          rsp_er;
  always @(negedge clk) begin
    if (rsp_vld === 1'b1) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_rd  = rsp_rdata;
      rsp_er  = rsp_err;
    end
    if (pio_start === 1'b1) hi_cnt++;
    if (pio_start === 1'b0 && pio_addr_wdata === 32'h5) d5_cnt++;
  end

  int acc_cyc = 0;

  task automatic send(input logic rw, input logic [NB-1:0] a, input logic [NB-1:0] d);
    int t = 0;
    req_vld = 1; req_rw = rw; req_addr = a; req_wdata = d;
    while (req_rdy !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_rdy", req_rdy, 1);
    acc_cyc = cyc;
    @(negedge clk);
    req_vld = 0;
  endtask

  task automatic wait_rsp(input int base, input int maxc);
    int t = 0;
    #1;
    while (rsp_cnt == base && t < maxc) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("rsp_wait", rsp_cnt - base, 1);
  endtask

  int base;

  initial begin
    rst = 1; req_vld = 0; req_rw = 0; req_addr = '0; req_wdata = '0;
    pio_ack = 0; pio_rvalid = 0; pio_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_pio_start", pio_start, 0);
    chk("rst_pio_rw", pio_rw, 0);
    chk("rst_pio_data", pio_addr_wdata, 0);
    @(negedge clk);

    // 1: write, ack two clks after the data beat
    base = rsp_cnt;
    send(0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_start", pio_start, 1);
    chk("t1_rw", pio_rw, 0);
    chk("t1_addr", pio_addr_wdata, 32'h10);
    @(negedge clk);
    chk("t1_start_lo", pio_start, 0);
    chk("t1_wdata", pio_addr_wdata, 32'hDEADBEEF);
    @(negedge clk);
    pio_ack = 1;
    @(negedge clk);
    pio_ack = 0;
    #1;
    chk("t1_rsp_cnt", rsp_cnt - base, 1);
    chk("t1_rsp_err", rsp_er, 0);
    chk("t1_rsp_rdata", rsp_rd, 0);
    chk("t1_latency", rsp_cyc - acc_cyc, 5);
    repeat (2) @(negedge clk);

    // 2: read; stray rvalid before ack is ignored, rvalid 3 clks after ack
    base = rsp_cnt;
    send(1, 32'h24, 0);
    @(negedge clk);
    chk("t2_start", pio_start, 1);
    chk("t2_rw", pio_rw, 1);
    chk("t2_addr", pio_addr_wdata, 32'h24);
    pio_rvalid = 1; pio_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t2_single_beat", pio_start, 0);
    chk("t2_no_data_beat", pio_addr_wdata, 0);
    pio_rvalid = 0; pio_rdata = '0; pio_ack = 1;
    @(negedge clk);
    pio_ack = 0;
    repeat (2) @(negedge clk);
    pio_rvalid = 1; pio_rdata = 32'h00C0FFEE;
    @(negedge clk);
    pio_rvalid = 0; pio_rdata = '0;
    #1;
    chk("t2_rsp_cnt", rsp_cnt - base, 1);
    chk("t2_rsp_rdata", rsp_rd, 32'h00C0FFEE);
    chk("t2_latency", rsp_cyc - acc_cyc, 7);
    repeat (2) @(negedge clk);

    // 3: clk_div one cycle in four
    div_mode = 1;
    hi_cnt = 0; d5_cnt = 0;
    base = rsp_cnt;
    send(0, 32'h8, 32'h5);
    repeat (10) @(negedge clk);
    pio_ack = 1;
    @(negedge clk);
    pio_ack = 0;
    wait_rsp(base, 10);
    chk("t3_start_hold", hi_cnt, 4);
    chk("t3_data_hold", d5_cnt, 4);
    chk("t3_rsp_err", rsp_er, 0);
    repeat (6) @(negedge clk);
    div_mode = 0;
    repeat (2) @(negedge clk);

    // 4: read with ack and rvalid together
    base = rsp_cnt;
    send(1, 32'h44, 0);
    @(negedge clk);
    pio_ack = 1; pio_rvalid = 1; pio_rdata = 32'h1234;
    @(negedge clk);
    pio_ack = 0; pio_rvalid = 0; pio_rdata = '0;
    #1;
    chk("t4_rsp_cnt", rsp_cnt - base, 1);
    chk("t4_rsp_rdata", rsp_rd, 32'h1234);
    chk("t4_latency", rsp_cyc - acc_cyc, 3);
    repeat (2) @(negedge clk);

    // 5: reset while waiting for read data; late rvalid/ack ignored
    base = rsp_cnt;
    send(1, 32'h40, 0);
    @(negedge clk);
    pio_ack = 1;
    @(negedge clk);
    pio_ack = 0; rst = 1;
    @(negedge clk);
    rst = 0; pio_rvalid = 1; pio_ack = 1; pio_rdata = 32'h55;
    @(negedge clk);
    pio_rvalid = 0; pio_ack = 0; pio_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_no_rsp", rsp_cnt - base, 0);
    chk("t5_req_rdy", req_rdy, 1);
    chk("t5_pio_start", pio_start, 0);
    chk("t5_pio_rw", pio_rw, 0);
    chk("t5_pio_data", pio_addr_wdata, 0);
    chk("t5_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);

    // 6: no ack at all
    base = rsp_cnt;
    send(0, 32'h30, 32'h77);
    if (TO_EN) begin
      wait_rsp(base, 40);
      chk("t6_rsp_err", rsp_er, 1);
      chk("t6_rsp_rdata", rsp_rd, 0);
      chk("t6_latency", rsp_cyc - acc_cyc, 19);
      repeat (3) @(negedge clk);
    end else begin
      repeat (10000) @(negedge clk);
      #1;
      chk("t6_no_rsp", rsp_cnt - base, 0);
      chk("t6_still_busy", req_rdy, 0);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
